// File: rtl/if_prefetch_queue.sv
`timescale 1ns/1ps
// Instruction-fetch prefetch queue: issues word fetches over a req/ack handshake and
// buffers {inst, pc} in a small FIFO feeding decode, with stall and redirect support.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] NOP      = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc4
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             stale_q, stale_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      last_pc_q;
    logic [31:0]      inst_mem_q [DEPTH];
    logic [31:0]      pc_mem_q   [DEPTH];

    logic        ack_w;
    logic        push;
    logic        pop;
    logic [31:0] redirect_pc_w;
    logic [31:0] next_pc;

    assign redirect_pc_w = redirect_pc & ~32'd3;
    assign ack_w         = (state_q == WAIT) && imem_ack;
    // A request issued before a redirect still completes, but its data is discarded.
    assign push          = ack_w && !stale_q && !redirect;
    assign pop           = inst_valid && !hold && !redirect;

    always_comb begin
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        if (redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        stale_d    = stale_q;
        next_pc    = stale_q ? fetch_pc_q : fetch_pc_q + 32'd4;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_w;
                end else if (count_d < FULL) begin
                    state_d = WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            WAIT: begin
                if (ack_w) begin
                    stale_d = 1'b0;
                    if (redirect) begin
                        fetch_pc_d = redirect_pc_w;
                        state_d    = IDLE;
                    end else begin
                        fetch_pc_d = next_pc;
                        if (count_d < FULL) addr_d = next_pc;
                        else                state_d = IDLE;
                    end
                end else if (redirect) begin
                    fetch_pc_d = redirect_pc_w;
                    stale_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= RESET_PC & ~32'd3;
            fetch_pc_q <= RESET_PC & ~32'd3;
            stale_q    <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_pc_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            stale_q    <= stale_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            last_pc_q  <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= addr_q;
        end
    end

    assign imem_req   = (state_q == WAIT);
    assign imem_addr  = addr_q;
    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? inst_mem_q[rd_ptr_q] : NOP;
    // With the queue empty the last head PC stays visible to decode.
    assign pc         = inst_valid ? pc_mem_q[rd_ptr_q] : last_pc_q;
    assign pc4        = pc + 32'd4;
endmodule

// File: tb/tb_if_prefetch_queue.sv
`timescale 1ns/1ps
// Bench for if_prefetch_queue: randomized memory latency, stalls and redirects checked
// against a queue-based model of the fetch stream plus directed scenarios.
module tb_if_prefetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        hold;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'd0), .NOP(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .hold(hold), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .pc(pc), .pc4(pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat_min, lat_max, hold_mode, redir_pct;
    bit          force_redir;
    logic [31:0] force_rpc;
    logic [31:0] exp_fetch, last_pc, busy_addr, last_req_addr;
    bit          busy, busy_stale;
    int          wait_cnt, req_count, cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[17:2]};
    endfunction

    function automatic logic [31:0] rand_target();
        logic [7:0] w;
        w = 8'($urandom_range(255, 0));
        if ($urandom_range(7, 0) == 0) return 32'hFFFF_FFF8;
        return {22'd0, w, 2'b00};
    endfunction

    task automatic tick();
        logic [31:0] shown_pc;
        bit          do_pop;
        ent_t        e;
        @(negedge clk);
        cyc++;
        check("valid", 32'(inst_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("pc", pc, q[0].pc);
            check("inst", inst, q[0].inst);
            check("pc4", pc4, q[0].pc + 32'd4);
            shown_pc = q[0].pc;
        end else begin
            check("nop", inst, NOP);
            check("pc_held", pc, last_pc);
            check("pc4_held", pc4, last_pc + 32'd4);
            shown_pc = last_pc;
        end
        if (busy) begin
            check("req_held", 32'(imem_req), 32'd1);
            check("addr_held", imem_addr, busy_addr);
        end else if (imem_req) begin
            check("req_addr", imem_addr, exp_fetch);
            check("req_space", 32'(q.size() < DEPTH), 32'd1);
            busy          = 1'b1;
            busy_stale    = 1'b0;
            busy_addr     = imem_addr;
            wait_cnt      = $urandom_range(lat_max, lat_min);
            req_count++;
            last_req_addr = imem_addr;
        end
        case (hold_mode)
            0:       hold = 1'b0;
            1:       hold = 1'b1;
            default: hold = ($urandom_range(99, 0) < 30);
        endcase
        if (force_redir) begin
            redirect    = 1'b1;
            redirect_pc = force_rpc;
            force_redir = 1'b0;
        end else if (redir_pct > 0 && $urandom_range(99, 0) < redir_pct) begin
            redirect    = 1'b1;
            redirect_pc = rand_target();
        end else begin
            redirect    = 1'b0;
            redirect_pc = $urandom;
        end
        imem_ack   = busy && (wait_cnt == 0);
        imem_rdata = imem_ack ? inst_of(busy_addr) : $urandom;
        do_pop = (q.size() != 0) && !hold && !redirect;
        if (do_pop) void'(q.pop_front());
        last_pc = shown_pc;
        if (imem_ack) begin
            if (!busy_stale && !redirect) begin
                e.pc   = busy_addr;
                e.inst = inst_of(busy_addr);
                q.push_back(e);
                exp_fetch = exp_fetch + 32'd4;
            end
            busy = 1'b0;
        end else if (busy) begin
            wait_cnt--;
        end
        if (redirect) begin
            q.delete();
            exp_fetch = redirect_pc & ~32'd3;
            if (busy) busy_stale = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        hold = 1'b0; redirect = 1'b0; redirect_pc = '0; force_redir = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, NOP);
        check("rst_pc", pc, 32'd0);
        check("rst_pc4", pc4, 32'd4);
        rst = 1'b0;
        q.delete();
        exp_fetch = 32'd0; last_pc = 32'd0; busy = 1'b0; busy_stale = 1'b0;
        wait_cnt = 0; req_count = 0; cyc = 0; last_req_addr = 32'd0;
    endtask

    task automatic wait_req(input int n);
        int guard = 0;
        while (req_count < n && guard < 100) begin tick(); guard++; end
        check("wait_req_bound", 32'(req_count >= n), 32'd1);
    endtask

    task automatic wait_valid();
        int guard = 0;
        do begin tick(); guard++; end while (!inst_valid && guard < 100);
        check("wait_valid_bound", 32'(inst_valid), 32'd1);
    endtask

    task automatic wait_fill(input int n);
        int guard = 0;
        while (q.size() < n && guard < 100) begin tick(); guard++; end
        check("wait_fill_bound", 32'(q.size() >= n), 32'd1);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        hold = 1'b0; redirect = 1'b0; redirect_pc = '0; force_redir = 1'b0; force_rpc = '0;
        redir_pct = 0;

        // zero-wait memory, no stalls
        lat_min = 0; lat_max = 0; hold_mode = 0;
        do_reset();
        tick();
        check("zw_c1_valid", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("zw_valid", 32'(inst_valid), 32'd1);
            check("zw_pc", pc, 32'(i * 4));
        end

        // 3-cycle memory with decode held: queue fills then fetching stops
        lat_min = 3; lat_max = 3; hold_mode = 1;
        do_reset();
        repeat (40) tick();
        check("hb_req_count", 32'(req_count), 32'd4);
        check("hb_req_low", 32'(imem_req), 32'd0);
        check("hb_head_pc", pc, 32'd0);
        hold_mode = 0;
        wait_req(5);
        check("hb_resume_addr", last_req_addr, 32'd16);
        repeat (10) tick();

        // redirect while waiting on 0x8
        lat_min = 3; lat_max = 3; hold_mode = 0;
        do_reset();
        wait_req(3);
        check("rd_wait_addr", last_req_addr, 32'h8);
        force_redir = 1'b1; force_rpc = 32'h40;
        tick();
        wait_req(4);
        check("rd_next_addr", last_req_addr, 32'h40);
        wait_valid();
        check("rd_pc", pc, 32'h40);
        check("rd_pc4", pc4, 32'h44);

        // redirect together with hold, three entries queued
        lat_min = 0; lat_max = 0; hold_mode = 1;
        do_reset();
        wait_fill(3);
        force_redir = 1'b1; force_rpc = 32'h100;
        tick();
        tick();
        check("rh_valid", 32'(inst_valid), 32'd0);
        check("rh_inst", inst, NOP);
        hold_mode = 0;
        wait_valid();
        check("rh_pc", pc, 32'h100);

        // full queue, single-cycle releases walk the pointers through wrap
        lat_min = 1; lat_max = 2; hold_mode = 1;
        do_reset();
        wait_fill(DEPTH);
        for (int k = 0; k < 10; k++) begin
            hold_mode = 0; tick(); hold_mode = 1;
            wait_fill(DEPTH);
            tick();
            check("wrap_req_low", 32'(imem_req), 32'd0);
            check("wrap_head_pc", pc, 32'(4 * (k + 1)));
        end
        hold_mode = 0;
        repeat (20) tick();

        // asynchronous reset in the middle of a fetch
        lat_min = 3; lat_max = 3; hold_mode = 0;
        do_reset();
        wait_req(1);
        #2 rst = 1'b1; imem_ack = 1'b0;
        #1;
        check("amid_req", 32'(imem_req), 32'd0);
        check("amid_valid", 32'(inst_valid), 32'd0);
        lat_min = 0; lat_max = 0;
        do_reset();
        wait_req(1);
        check("amid_refetch", last_req_addr, 32'd0);

        // randomized latency, stalls and redirects
        lat_min = 0; lat_max = 3; hold_mode = 2; redir_pct = 5;
        do_reset();
        repeat (3000) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
